// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer control stage.
// State encoding is visible on the state output, so values are fixed.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_e;

    localparam logic [3:0] MAX_DIGIT    = 4'd9;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;

    // A load is only sensible for a non-zero time whose seconds-tens is a real seconds digit.
    function automatic logic entry_startable(input logic [15:0] entry);
        return (entry != 16'h0000) && (entry[7:4] <= MAX_SEC_TENS);
    endfunction

    function automatic logic digits_are_zero(input logic [3:0] min_tens,
                                             input logic [3:0] min_ones,
                                             input logic [3:0] sec_tens,
                                             input logic [3:0] sec_ones);
        return {min_tens, min_ones, sec_tens, sec_ones} == 16'h0000;
    endfunction

endpackage

// File: rtl/egg_timer_ctrl_sec_prescaler.sv
// One-second prescaler shared by the run countdown and the alarm duration.
// tick flags that the count sits on its terminal value, so the next enabled cycle wraps.
module sec_prescaler #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next count: clear wins, otherwise count while enabled and wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        tick_d = (cnt_d == LAST);
    end

    // Counter and terminal-count flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= {CNT_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer control: keypad entry, load/decrement strobes for the BCD
// decrementer, and a timed alarm once the decrementer reaches 00:00.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int ALARM_SECS    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        digitValid,
    input  logic [3:0]  digit,
    input  logic        startKey,
    input  logic        stopKey,
    input  logic        clearKey,
    input  logic [3:0]  secOnes,
    input  logic [3:0]  secTens,
    input  logic [3:0]  minOnes,
    input  logic [3:0]  minTens,
    output logic [15:0] minsSecsOut,
    output logic        wrtEn,
    output logic        decEn,
    output logic        running,
    output logic        alarm,
    output logic [1:0]  state
);

    localparam int ASEC_W = $clog2(ALARM_SECS + 1);
    localparam logic [ASEC_W-1:0] ASEC_LAST = ASEC_W'(ALARM_SECS - 1);

    state_e              state_q;
    state_e              state_d;
    logic [15:0]         entry_q;
    logic [15:0]         entry_d;
    logic                loaded_q;
    logic                loaded_d;
    logic                wrt_en_q;
    logic                wrt_en_d;
    logic                dec_en_q;
    logic                dec_en_d;
    logic                running_q;
    logic                running_d;
    logic                alarm_q;
    logic                alarm_d;
    logic [ASEC_W-1:0]   alarm_secs_q;
    logic [ASEC_W-1:0]   alarm_secs_d;
    logic                presc_en_s;
    logic                presc_clr_s;
    logic                presc_tick_s;
    logic                digits_zero_s;

    assign digits_zero_s = digits_are_zero(minTens, minOnes, secTens, secOnes);

    sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (presc_en_s),
        .clear  (presc_clr_s),
        .tick   (presc_tick_s)
    );

    // Next-state, entry and strobe logic; clearKey overrides every state.
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        loaded_d     = loaded_q;
        wrt_en_d     = 1'b0;
        dec_en_d     = 1'b0;
        presc_en_s   = 1'b0;
        presc_clr_s  = 1'b0;
        alarm_secs_d = alarm_secs_q;

        if (clearKey) begin
            state_d      = IDLE;
            entry_d      = 16'h0000;
            loaded_d     = 1'b0;
            wrt_en_d     = 1'b1;
            presc_clr_s  = 1'b1;
            alarm_secs_d = {ASEC_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    presc_clr_s  = 1'b1;
                    alarm_secs_d = {ASEC_W{1'b0}};
                    loaded_d     = 1'b0;
                    if (stopKey) begin
                        entry_d = entry_q;
                    end else if (startKey) begin
                        if (entry_startable(entry_q)) begin
                            state_d  = RUN;
                            wrt_en_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (digitValid && (digit <= MAX_DIGIT)) begin
                        entry_d = {entry_q[11:0], digit};
                    end else begin
                        entry_d = entry_q;
                    end
                end
                RUN: begin
                    // The decrementer holds valid digits only after the wrtEn cycle.
                    loaded_d = loaded_q | wrt_en_q;
                    if (stopKey) begin
                        state_d = PAUSE;
                    end else if (loaded_q && digits_zero_s) begin
                        state_d      = ALARM;
                        presc_clr_s  = 1'b1;
                        alarm_secs_d = {ASEC_W{1'b0}};
                    end else begin
                        presc_en_s = 1'b1;
                        dec_en_d   = presc_tick_s;
                    end
                end
                PAUSE: begin
                    if (stopKey) begin
                        state_d = PAUSE;
                    end else if (startKey) begin
                        state_d = RUN;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                ALARM: begin
                    if (startKey || stopKey) begin
                        state_d     = IDLE;
                        entry_d     = 16'h0000;
                        presc_clr_s = 1'b1;
                    end else begin
                        presc_en_s = 1'b1;
                        if (presc_tick_s) begin
                            if (alarm_secs_q == ASEC_LAST) begin
                                state_d     = IDLE;
                                entry_d     = 16'h0000;
                                presc_clr_s = 1'b1;
                            end else begin
                                alarm_secs_d = alarm_secs_q + ASEC_W'(1);
                            end
                        end else begin
                            alarm_secs_d = alarm_secs_q;
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    entry_d     = 16'h0000;
                    presc_clr_s = 1'b1;
                end
            endcase
        end

        running_d = (state_d == RUN);
        alarm_d   = (state_d == ALARM);
    end

    // State, entry and registered output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            entry_q      <= 16'h0000;
            loaded_q     <= 1'b0;
            wrt_en_q     <= 1'b0;
            dec_en_q     <= 1'b0;
            running_q    <= 1'b0;
            alarm_q      <= 1'b0;
            alarm_secs_q <= {ASEC_W{1'b0}};
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            loaded_q     <= loaded_d;
            wrt_en_q     <= wrt_en_d;
            dec_en_q     <= dec_en_d;
            running_q    <= running_d;
            alarm_q      <= alarm_d;
            alarm_secs_q <= alarm_secs_d;
        end
    end

    assign minsSecsOut = entry_q;
    assign wrtEn       = wrt_en_q;
    assign decEn       = dec_en_q;
    assign running     = running_q;
    assign alarm       = alarm_q;
    assign state       = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: behavioural decrementer in the loop, a cycle-level
// reference model of the controller, a vector table and directed corner sequences.
module tb_egg_timer_ctrl;

    localparam int TPS = 4;
    localparam int AS  = 2;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        digitValid = 1'b0;
    logic [3:0]  digit      = 4'd0;
    logic        startKey   = 1'b0;
    logic        stopKey    = 1'b0;
    logic        clearKey   = 1'b0;
    logic [3:0]  secOnes, secTens, minOnes, minTens;
    logic [15:0] mso;
    logic        wrtEn, decEn, running, alarm;
    logic [1:0]  state;

    int dec_mm = 0;
    int dec_ss = 0;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state (spec encoding: 0 idle, 1 run, 2 pause, 3 alarm)
    int m_state, m_entry, m_phase, m_alarm_cyc;
    bit m_loaded, m_wrt, m_dec;

    egg_timer_ctrl #(.TICKS_PER_SEC(TPS), .ALARM_SECS(AS)) dut (
        .clk(clk), .reset(reset_n), .digitValid(digitValid), .digit(digit),
        .startKey(startKey), .stopKey(stopKey), .clearKey(clearKey),
        .secOnes(secOnes), .secTens(secTens), .minOnes(minOnes), .minTens(minTens),
        .minsSecsOut(mso), .wrtEn(wrtEn), .decEn(decEn), .running(running),
        .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    assign secOnes = 4'(dec_ss % 10);
    assign secTens = 4'(dec_ss / 10);
    assign minOnes = 4'(dec_mm % 10);
    assign minTens = 4'(dec_mm / 10);

    // behavioural BCD MM:SS decrementer fed by the DUT strobes
    always @(posedge clk) begin
        if (wrtEn) begin
            dec_mm <= int'(mso[15:12]) * 10 + int'(mso[11:8]);
            dec_ss <= int'(mso[7:4]) * 10 + int'(mso[3:0]);
        end else if (decEn) begin
            if (dec_ss > 0) begin
                dec_ss <= dec_ss - 1;
            end else if (dec_mm > 0) begin
                dec_mm <= dec_mm - 1;
                dec_ss <= 59;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_entry = 0; m_phase = 0; m_alarm_cyc = 0;
        m_loaded = 0; m_wrt = 0; m_dec = 0;
    endtask

    // predicts the outputs after the coming clock edge from this cycle's inputs
    task automatic model_step(input bit c, input bit s, input bit g, input bit v, input logic [3:0] d);
        bit wrt_prev = m_wrt;
        m_wrt = 0;
        m_dec = 0;
        if (c) begin
            m_state = 0; m_entry = 0; m_wrt = 1; m_loaded = 0; m_phase = 0;
        end else begin
            case (m_state)
                0: if (!s) begin
                    if (g) begin
                        if (m_entry != 0 && (m_entry / 10) % 10 <= 5) begin
                            m_state = 1; m_wrt = 1; m_phase = 0; m_loaded = 0;
                        end
                    end else if (v && d <= 4'd9) begin
                        m_entry = (m_entry * 10 + int'(d)) % 10000;
                    end
                end
                1: begin
                    if (s) begin
                        m_state = 2;
                    end else if (m_loaded && dec_mm == 0 && dec_ss == 0) begin
                        m_state = 3; m_alarm_cyc = 0;
                    end else begin
                        m_phase++;
                        if (m_phase == TPS) begin
                            m_phase = 0; m_dec = 1;
                        end
                    end
                    if (wrt_prev) m_loaded = 1;
                end
                2: if (!s && g) m_state = 1;
                default: begin
                    if (g || s) begin
                        m_state = 0; m_entry = 0;
                    end else begin
                        m_alarm_cyc++;
                        if (m_alarm_cyc == TPS * AS) begin
                            m_state = 0; m_entry = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    // one clock cycle: drive inputs mid-cycle, advance model, compare after the edge
    task automatic step(input bit c, input bit s, input bit g, input bit v, input logic [3:0] d);
        @(negedge clk);
        clearKey = c; stopKey = s; startKey = g; digitValid = v; digit = d;
        model_step(c, s, g, v, d);
        @(posedge clk);
        #1;
        check("model", {10'b0, state, running, alarm, wrtEn, decEn, mso},
              {10'b0, 2'(m_state), m_state == 1, m_state == 3, m_wrt, m_dec, to_bcd(m_entry)});
        clearKey = 0; stopKey = 0; startKey = 0; digitValid = 0; digit = 4'd0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic key_digit(input logic [3:0] d);
        step(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic wait_dec(input int bound, output int n);
        n = 0;
        do begin
            idle();
            n++;
        end while (!decEn && n < bound);
    endtask

    typedef struct {
        bit c, s, g, v;
        logic [3:0] d;
        logic [1:0] e_state;
        bit e_wrt;
        logic [15:0] e_entry;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n, decs, acyc, bad;
        bit seen_alarm;

        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 2'd0, 1'b0, 16'h0007});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 16'h0070});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 16'h0070});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 2'd0, 1'b0, 16'h0070});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 2'd0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 2'd0, 1'b0, 16'h0001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 2'd0, 1'b0, 16'h0013});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 16'h0130});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd1, 1'b1, 16'h0130});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0, 16'h0130});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 2'd1, 1'b0, 16'h0130});

        // reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {10'b0, state, running, alarm, wrtEn, decEn, mso}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // invalid starts, then entry 01:30 and a valid start
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c, vecs[i].s, vecs[i].g, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d_state", i), state, vecs[i].e_state);
            check($sformatf("vec%0d_wrtEn", i), wrtEn, vecs[i].e_wrt);
            check($sformatf("vec%0d_entry", i), mso, vecs[i].e_entry);
        end

        // first decEn four cycles after wrtEn, then once per second
        idle();
        check("t1_no_early_dec", decEn, 1'b0);
        idle();
        check("t1_first_dec", decEn, 1'b1);
        wait_dec(10, n);
        check("t1_period_a", n, 4);
        check("t1_decr_0129", {dec_mm[15:0], dec_ss[15:0]}, {16'd1, 16'd29});
        wait_dec(10, n);
        check("t1_period_b", n, 4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // 00:02 counts down to zero and alarms for ALARM_SECS seconds
        key_digit(4'd0); key_digit(4'd0); key_digit(4'd0); key_digit(4'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        decs = 0; acyc = 0; seen_alarm = 0; n = 0;
        while (n < 60 && !(seen_alarm && state == 2'd0)) begin
            idle();
            n++;
            if (decEn) decs++;
            if (alarm) acyc++;
            if (state == 2'd3) seen_alarm = 1;
        end
        check("t2_dec_count", decs, 2);
        check("t2_alarm_cycles", acyc, 8);
        check("t2_alarm_seen", seen_alarm, 1'b1);
        check("t2_back_idle", state, 2'd0);
        check("t2_entry_zero", mso, 16'h0000);
        decs = 0;
        repeat (8) begin
            idle();
            if (decEn) decs++;
        end
        check("t2_no_third_dec", decs, 0);

        // pause two cycles after a decEn, resume later
        key_digit(4'd0); key_digit(4'd5); key_digit(4'd0); key_digit(4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_dec(10, n);
        check("t3_first_dec", n, 4);
        idle();
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("t3_paused", state, 2'd2);
        bad = 0;
        repeat (10) begin
            idle();
            if (decEn || wrtEn || state != 2'd2) bad++;
        end
        check("t3_pause_quiet", bad, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("t3_resumed", state, 2'd1);
        check("t3_no_wrt", wrtEn, 1'b0);
        idle();
        check("t3_resume_gap", decEn, 1'b0);
        idle();
        check("t3_resume_dec", decEn, 1'b1);

        // clear beats start in the same cycle
        idle();
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        check("t5_state", state, 2'd0);
        check("t5_wrt", wrtEn, 1'b1);
        check("t5_entry", mso, 16'h0000);
        idle();
        check("t5_wrt_single", wrtEn, 1'b0);
        check("t5_decr_zero", {dec_mm[15:0], dec_ss[15:0]}, 32'h0);

        // asynchronous reset mid-run
        key_digit(4'd0); key_digit(4'd1); key_digit(4'd0); key_digit(4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (6) idle();
        check("t6_running_before", running, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_clear", {state, running, alarm, wrtEn, decEn}, 6'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("t6_held", {10'b0, state, running, alarm, wrtEn, decEn, mso}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (12) begin
            idle();
            if (wrtEn || decEn || state != 2'd0) bad++;
        end
        check("t6_quiet_after", bad, 0);

        // random stimulus against the reference model
        for (int i = 0; i < 800; i++) begin
            bit c, s, g, v;
            logic [3:0] d;
            c = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 29) == 0);
            g = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11)) : 4'd0;
            step(c, s, g, v, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/egg_timer_ctrl.md
Name: egg_timer_ctrl

Overview:
Control stage directly upstream of the countdown digit register (the decrementer, which holds BCD MM:SS).
- Assembles keypad digits into a 16-bit BCD MM:SS entry value.
- Drives the decrementer's load (wrtEn) and one-per-second decrement (decEn) strobes.
- Watches the decrementer's digits for 00:00 and raises a timed alarm.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; must be >= 2.
ALARM_SECS, 10, alarm duration in seconds; must be >= 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
digitValid  in  1  one-cycle pulse; digit is valid
digit  in  4  keypad digit, BCD
startKey  in  1  one-cycle pulse, debounced
stopKey  in  1  one-cycle pulse, debounced
clearKey  in  1  one-cycle pulse, debounced
secOnes  in  4  decrementer seconds-ones digit
secTens  in  4  decrementer seconds-tens digit
minOnes  in  4  decrementer minutes-ones digit
minTens  in  4  decrementer minutes-tens digit
minsSecsOut  out  16  entry value {minTens,minOnes,secTens,secOnes}; feeds the decrementer minsSecsIn
wrtEn  out  1  one-cycle load strobe to the decrementer
decEn  out  1  one-cycle decrement strobe to the decrementer
running  out  1  high while state == RUN
alarm  out  1  high while state == ALARM
state  out  2  current state, encoded per package

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, entry=16'h0000, prescaler=0, loaded=0. Outputs wrtEn, decEn, alarm, running all 0.
- All outputs are registered.
- Input priority when several inputs coincide: clearKey > stopKey > startKey > digitValid.
- States: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- IDLE:
  - digitValid with digit <= 9: entry <= {entry[11:0], digit}. digit > 9 is ignored.
  - startKey is accepted only if entry != 0 and entry[7:4] <= 5. On accept: next state RUN; wrtEn=1 for exactly the first RUN cycle; prescaler=0; loaded=0.
  - startKey otherwise: ignored, no wrtEn.
- RUN:
  - The decrementer captures at the edge ending the wrtEn cycle. loaded is set 1 after that cycle.
  - The zero check is active only when loaded=1.
  - Prescaler counts 0..TICKS_PER_SEC-1 and wraps. decEn=1 in the cycle after the prescaler wraps, so the first decEn comes TICKS_PER_SEC cycles after wrtEn. decEn is never asserted together with wrtEn.
  - loaded=1 and all four input digits == 0: next state ALARM; decEn suppressed; prescaler=0.
  - stopKey: next state PAUSE; prescaler holds its value; no decEn.
  - digitValid is ignored.
- PAUSE:
  - Prescaler frozen.
  - startKey: back to RUN with the prescaler resumed; no wrtEn; loaded unchanged.
  - stopKey and digitValid are ignored.
- ALARM:
  - alarm=1.
  - The prescaler counts ALARM_SECS full seconds, then next state IDLE.
  - startKey or stopKey ends the alarm early: next state IDLE.
  - On any exit from ALARM: entry=0 and alarm=0.
- clearKey, any state: next state IDLE, entry=0, prescaler=0, alarm=0, plus a one-cycle wrtEn (minsSecsOut=0) so the decrementer is zeroed. This applies even in IDLE.
- minsSecsOut always equals entry. entry is frozen outside IDLE except on clear.
- Reset mid-operation: immediate return to reset values, no strobes emitted.

Decomposition:
- Package egg_timer_pkg: 2-bit state enum (IDLE/RUN/PAUSE/ALARM); constants MAX_DIGIT=4'd9 and MAX_SEC_TENS=4'd5.
- One sub-module, sec_prescaler, with ports clk, reset, enable, clear, tick.
  - Counter width is $clog2(TICKS_PER_SEC).
  - tick is registered and high for one cycle per wrap.
  - It is reused for both the RUN decrement timing and the ALARM duration count.

Test Plan:
Bench uses TICKS_PER_SEC=4, ALARM_SECS=2, and a behavioural decrementer model.
1. Digits 0,1,3,0 then start -> minsSecsOut=16'h0130; wrtEn high exactly 1 cycle; state=1; decEn every 4 cycles; model shows 01:29 after first decEn.
2. Load 00:02, start -> two decEn pulses; zero detected; state=3 with alarm=1 for 8 cycles; then state=0, entry=0, and no third decEn.
3. Running, stopKey 2 cycles after a decEn -> state=2 with no decEn for 10 cycles; startKey -> next decEn exactly 2 cycles later; no wrtEn.
4. Invalid start cases, each leaving state=0 with no wrtEn:
   - digits 0,0,7,0 then start (secTens=7);
   - start with entry=0;
   - digit=4'hA (minsSecsOut unchanged).
5. RUN with clearKey and startKey in the same cycle -> state=0, entry=0, one wrtEn with minsSecsOut=0.
6. reset driven low between clock edges mid-RUN -> state, wrtEn, decEn, alarm, running all 0 without a clock edge; no strobes after release until a new start.
